multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core variant.
- Sequences fetch/decode/execute/memory/writeback over a shared ALU, memory port and immediate extender.
- Drives ImmSrc to the extender plus all datapath mux selects and write strobes.
- Handles a ready/req memory handshake and halts on illegal instructions.

---
 rtl/multicycle_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl_alu_decoder.sv | 31 +++
 rtl/multicycle_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds the state enum, datapath select encodings and major opcodes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: instruction fields and flags in,
// mux selects, write strobes, memory handshake and status out.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state_o
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder; flags funct3 values the ALU cannot execute.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] ALUControl,
    output logic       bad_funct
);

    always_comb begin
        ALUControl = ALU_ADD;
        bad_funct  = 1'b0;
        case (ALUOp)
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: bad_funct  = 1'b1;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core. Optional performance
// counters (retired_cnt, cycle_cnt) are built when CTRL_PERF_EN is defined.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | register read, branch/jump target into ALUOut
// MEMADR   | rs1 + imm load/store address
// MEMREAD  | load data access
// MEMWB    | load data to register file
// MEMWRITE | store access
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | ALUOut to register file
// BRANCH   | compare rs1/rs2, conditional PC update
// JAL      | PC <= target, compute OldPC+4
// HALT     | illegal instruction or memory timeout, exit only by reset
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0
)
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       cycle_cnt
`endif
);

    localparam logic [31:0] WAIT_LAST = (MEM_WAIT_MAX > 0) ? 32'(MEM_WAIT_MAX - 1) : 32'd0;

    state_t      state, state_next;
    logic        req, pc_write, mem_write, ir_write, reg_write, adr_src;
    logic [1:0]  res_src, src_a, src_b, imm_src, alu_op;
    logic [2:0]  alu_control;
    logic        bad_funct;
    logic        in_mem, waiting, timeout;
    logic [31:0] wait_cnt;

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .funct3     (bus.funct3),
        .funct7b5   (bus.funct7b5),
        .op5        (bus.op[5]),
        .ALUControl (alu_control),
        .bad_funct  (bad_funct)
    );

    // Memory-wait timeout; derived from state only to keep the next-state logic loop free.
    assign in_mem  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign waiting = in_mem && !bus.mem_ready;
    assign timeout = (MEM_WAIT_MAX > 0) && waiting && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                     wait_cnt <= '0;
        else if (MEM_WAIT_MAX == 0 || !waiting || state_next != state) wait_cnt <= '0;
        else                                                         wait_cnt <= wait_cnt + 32'd1;
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        res_src    = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                req      = 1'b1;
                src_b    = SRCB_FOUR;
                res_src  = RES_ALURESULT;
                ir_write = bus.mem_ready;
                pc_write = bus.mem_ready;
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_IMM;
                imm_src = (bus.op == OP_JAL) ? IMM_J : IMM_B;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                imm_src    = bus.op[5] ? IMM_S : IMM_I;
                state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req     = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                res_src    = RES_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                req       = 1'b1;
                adr_src   = 1'b1;
                mem_write = bus.mem_ready;
                if (bus.mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                state_next = bad_funct ? S_HALT : S_ALUWB;
            end
            S_EXECI: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                imm_src    = IMM_I;
                alu_op     = ALUOP_FUNCT;
                state_next = bad_funct ? S_HALT : S_ALUWB;
            end
            S_ALUWB: begin
                res_src    = RES_ALUOUT;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_RS2;
                alu_op  = ALUOP_SUB;
                res_src = RES_ALUOUT;
                case (bus.funct3)
                    3'b000: begin
                        pc_write   = bus.Zero;
                        state_next = S_FETCH;
                    end
                    3'b001: begin
                        pc_write   = !bus.Zero;
                        state_next = S_FETCH;
                    end
                    default: state_next = S_HALT;
                endcase
            end
            S_JAL: begin
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                imm_src    = IMM_J;
                res_src    = RES_ALUOUT;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
        if (timeout) state_next = S_HALT;
    end

    // Strobes and the request are cut combinationally so a reset mid-access never leaks a write.
    assign bus.mem_req    = req & ~rst;
    assign bus.PCWrite    = pc_write & ~rst;
    assign bus.MemWrite   = mem_write & ~rst;
    assign bus.IRWrite    = ir_write & ~rst;
    assign bus.RegWrite   = reg_write & ~rst;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = res_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src;
    assign bus.illegal    = (state == S_HALT);
    assign bus.state_o    = state;

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (state_next == S_FETCH &&
                (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB || state == S_BRANCH))
                retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expectations are built
// from instruction-level phase rules and compared on every falling edge.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl_if bus2();

`ifdef CTRL_PERF_EN
    logic [31:0] ret1, cyc1, ret2, cyc2;
    multicycle_ctrl #(.MEM_WAIT_MAX(0)) dut (.clk(clk), .rst(rst), .bus(bus), .retired_cnt(ret1), .cycle_cnt(cyc1));
    multicycle_ctrl #(.MEM_WAIT_MAX(5)) dut2 (.clk(clk), .rst(rst2), .bus(bus2), .retired_cnt(ret2), .cycle_cnt(cyc2));
`else
    multicycle_ctrl #(.MEM_WAIT_MAX(0)) dut (.clk(clk), .rst(rst), .bus(bus));
    multicycle_ctrl #(.MEM_WAIT_MAX(5)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));
`endif

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       rdy;
        logic       zero;
        state_t     st;
        logic       req, pcw, adr, memw, irw, regw;
        logic [1:0] res, srca, srcb;
        logic [2:0] aluc;
        logic [1:0] imm;
        logic       ill;
    } cyc_t;

    cyc_t exp_q[$];
    cyc_t cur;
    logic cur_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_req, n_irw, n_regw, n_pcw, n_memw;

    logic [6:0] i_op;
    logic [2:0] i_f3;
    logic       i_f7, i_zero;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_tally();
        n_req = 0; n_irw = 0; n_regw = 0; n_pcw = 0; n_memw = 0;
    endtask

    function automatic cyc_t blank(input state_t s, input logic rdy);
        cyc_t c;
        c.op = i_op; c.f3 = i_f3; c.f7 = i_f7; c.zero = i_zero;
        c.rdy = rdy; c.st = s;
        c.req = 0; c.pcw = 0; c.adr = 0; c.memw = 0; c.irw = 0; c.regw = 0;
        c.res = 2'b00; c.srca = 2'b00; c.srcb = 2'b00; c.aluc = 3'b000; c.imm = 2'b00;
        c.ill = (s == S_HALT);
        return c;
    endfunction

    // {bad, control} for an ALU-funct instruction.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic subsel);
        case (f3)
            3'b000:  return subsel ? 4'b0001 : 4'b0000;
            3'b010:  return 4'b0101;
            3'b110:  return 4'b0011;
            3'b111:  return 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(blank(S_HALT, 1'b1));
    endtask

    // Expected cycle list for one instruction from fetch to its last state.
    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input int halt_n);
        cyc_t c;
        logic [3:0] a;
        i_op = op; i_f3 = f3; i_f7 = f7; i_zero = z;
        for (int i = 0; i <= fw; i++) begin
            c = blank(S_FETCH, i == fw);
            c.req = 1; c.srcb = 2'b10; c.res = 2'b10;
            c.irw = (i == fw); c.pcw = (i == fw);
            exp_q.push_back(c);
        end
        c = blank(S_DECODE, 1'b1);
        c.srca = 2'b01; c.srcb = 2'b01; c.imm = (op == 7'b1101111) ? 2'b11 : 2'b10;
        exp_q.push_back(c);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            c = blank(S_MEMADR, 1'b1);
            c.srca = 2'b10; c.srcb = 2'b01; c.imm = (op == 7'b0100011) ? 2'b01 : 2'b00;
            exp_q.push_back(c);
            for (int i = 0; i <= mw; i++) begin
                c = blank((op == 7'b0100011) ? S_MEMWRITE : S_MEMREAD, i == mw);
                c.req = 1; c.adr = 1;
                c.memw = (op == 7'b0100011) && (i == mw);
                exp_q.push_back(c);
            end
            if (op == 7'b0000011) begin
                c = blank(S_MEMWB, 1'b1);
                c.res = 2'b01; c.regw = 1;
                exp_q.push_back(c);
            end
        end else if (op == 7'b0110011 || op == 7'b0010011) begin
            a = alu_of(f3, op[5] & f7);
            c = blank((op == 7'b0110011) ? S_EXECR : S_EXECI, 1'b1);
            c.srca = 2'b10; c.srcb = (op == 7'b0110011) ? 2'b00 : 2'b01; c.aluc = a[2:0];
            exp_q.push_back(c);
            if (a[3]) push_halt(halt_n);
            else begin
                c = blank(S_ALUWB, 1'b1);
                c.regw = 1;
                exp_q.push_back(c);
            end
        end else if (op == 7'b1100011) begin
            c = blank(S_BRANCH, 1'b1);
            c.srca = 2'b10; c.aluc = 3'b001;
            c.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
            exp_q.push_back(c);
            if (f3 > 3'b001) push_halt(halt_n);
        end else if (op == 7'b1101111) begin
            c = blank(S_JAL, 1'b1);
            c.srca = 2'b01; c.srcb = 2'b10; c.imm = 2'b11; c.pcw = 1;
            exp_q.push_back(c);
            c = blank(S_ALUWB, 1'b1);
            c.regw = 1;
            exp_q.push_back(c);
        end else begin
            push_halt(halt_n);
        end
    endtask

    task automatic run_queue(input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(posedge clk); #1;
            rst = 1'b0;
            cur = exp_q.pop_front();
            bus.op = cur.op; bus.funct3 = cur.f3; bus.funct7b5 = cur.f7;
            bus.mem_ready = cur.rdy; bus.Zero = cur.zero;
            cur_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        #1 cur_valid = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [21:0] pack_exp(input cyc_t c);
        return {c.st, c.req, c.pcw, c.adr, c.memw, c.irw, c.regw, c.res, c.srca, c.srcb, c.aluc, c.imm, c.ill};
    endfunction

    always @(negedge clk) begin
        if (cur_valid) begin
            chk($sformatf("cycle_%s", cur.st.name()),
                32'({bus.state_o, bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                     bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                     bus.ImmSrc, bus.illegal}),
                32'(pack_exp(cur)));
            n_req  += int'(bus.mem_req);
            n_irw  += int'(bus.IRWrite);
            n_regw += int'(bus.RegWrite);
            n_pcw  += int'(bus.PCWrite);
            n_memw += int'(bus.MemWrite);
        end
    end

    // Mid-cycle async reset with mem_ready high: strobes and request must vanish at once.
    task automatic async_reset(input string tag);
        bus.mem_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk({tag, "_state"}, 32'(bus.state_o), 32'(S_FETCH));
        chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
        chk({tag, "_strobes"}, 32'({bus.mem_req, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 32'd0);
    endtask

    initial begin
        int n;
        i_op = '0; i_f3 = '0; i_f7 = 1'b0; i_zero = 1'b0;
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        bus2.op = '0; bus2.funct3 = '0; bus2.funct7b5 = 1'b0; bus2.Zero = 1'b0; bus2.mem_ready = 1'b0;
        clear_tally();

        #12;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_strobes", 32'({bus.mem_req, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 32'd0);
        chk("rst_fetch_sel", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc}), 32'b00_10_10_0);

        // add x3,x1,x2
        gen_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 0);
        chk("model_add_len", 32'(exp_q.size()), 32'd4);
        clear_tally();
        run_queue(1000);
        chk("add_pcw_count", 32'(n_pcw), 32'd1);
        chk("add_regw_count", 32'(n_regw), 32'd1);

        // sub, addi with funct7b5 set, slt, or, and
        gen_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 0);
        gen_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1, 0, 0);
        gen_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, 0);
        gen_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 0);
        gen_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 2, 0, 0);
        run_queue(1000);

        // lw with three wait cycles in fetch and memread
        gen_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3, 3, 0);
        chk("model_lw_len", 32'(exp_q.size()), 32'd11);
        clear_tally();
        run_queue(1000);
        chk("lw_req_cycles", 32'(n_req), 32'd8);
        chk("lw_irw_pulses", 32'(n_irw), 32'd1);
        chk("lw_regw_pulses", 32'(n_regw), 32'd1);

        // beq / bne with Zero both ways
        clear_tally();
        gen_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 0);
        run_queue(1000);
        chk("beq_z1_pcw", 32'(n_pcw), 32'd2);
        clear_tally();
        gen_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 0);
        run_queue(1000);
        chk("bne_z1_pcw", 32'(n_pcw), 32'd1);
        gen_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 0);
        gen_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 0);
        run_queue(1000);

        // sw with two wait cycles
        clear_tally();
        gen_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2, 0);
        run_queue(1000);
        chk("sw_memw_pulses", 32'(n_memw), 32'd1);
        chk("sw_regw_pulses", 32'(n_regw), 32'd0);

        // jal, then a long fetch stall (no timeout on the default instance)
        gen_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 0);
        gen_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 30, 0, 0);
        run_queue(1000);

        // illegal opcode: HALT held for 20 cycles, then async reset
        gen_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 20);
        run_queue(1000);
        async_reset("halt_rst");

        // bad funct3 in EXECR
        gen_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, 3);
        run_queue(1000);
        async_reset("badfunct_rst");

        // bad branch funct3
        gen_instr(7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0, 3);
        run_queue(1000);
        async_reset("badbr_rst");

        // reset in the middle of a stalled store
        gen_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, 0);
        run_queue(4);
        bus.mem_ready = 1'b1;
        #1 chk("midstore_memw_live", 32'(bus.MemWrite), 32'd1);
        async_reset("midstore_rst");

        // recovery after reset
        gen_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0, 0);
        run_queue(1000);

        // MEM_WAIT_MAX=5 instance with mem_ready held low
        @(posedge clk); #1;
        rst2 = 1'b0;
        n = 0;
        while (bus2.state_o != 4'(S_HALT) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd5);
        chk("timeout_illegal", 32'(bus2.illegal), 32'd1);
        chk("timeout_req", 32'(bus2.mem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
